// File: rtl/shift_arb_pkg.sv
// rtl/shift_arb_pkg.sv - shared constants, requester ids and result-slot state for shift_arbiter
package shift_arb_pkg;

    localparam int DATA_W = 8;
    localparam int SH_W   = 3;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

endpackage

// File: rtl/lshift8_stage.sv
// rtl/lshift8_stage.sv - combinational 8-bit left shifter (1/2/4 mux stages)
// SHIFT_ARB_ROTATE_EN adds a rot input that feeds MSB overflow back into the LSBs
module lshift8_stage
    import shift_arb_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    input  logic [SH_W-1:0]   amt,
`ifdef SHIFT_ARB_ROTATE_EN
    input  logic              rot,
`endif
    output logic [DATA_W-1:0] result
);

    logic              fill_en;
    logic [DATA_W-1:0] s1;
    logic [DATA_W-1:0] s2;

`ifdef SHIFT_ARB_ROTATE_EN
    assign fill_en = rot;
`else
    assign fill_en = 1'b0;
`endif

    // Bits shifted out of the top only re-enter when rotating; otherwise zero fill
    assign s1     = amt[0] ? {data[6:0], data[7] & fill_en}          : data;
    assign s2     = amt[1] ? {s1[5:0], s1[7:6] & {2{fill_en}}}       : s1;
    assign result = amt[2] ? {s2[3:0], s2[7:4] & {4{fill_en}}}       : s2;

endmodule

// File: rtl/shift_arbiter.sv
// rtl/shift_arbiter.sv - round-robin arbiter sharing one 8-bit left shifter with a registered result
// SHIFT_ARB_ROTATE_EN adds per-requester rotate select ports
module shift_arbiter #(
    parameter int DATA_W = shift_arb_pkg::DATA_W,
    parameter int SH_W   = shift_arb_pkg::SH_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    input  logic [SH_W-1:0]   req0_amt,
`ifdef SHIFT_ARB_ROTATE_EN
    input  logic              req0_rot,
`endif
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    input  logic [SH_W-1:0]   req1_amt,
`ifdef SHIFT_ARB_ROTATE_EN
    input  logic              req1_rot,
`endif
    output logic              req1_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_id,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  done_cnt
);
    import shift_arb_pkg::*;

    state_e            state;
    logic              last_gnt;
    logic              can_accept;
    logic              gnt_any;
    logic              gnt_id;
    logic              accept;
    logic [DATA_W-1:0] sel_data;
    logic [SH_W-1:0]   sel_amt;
    logic [DATA_W-1:0] shifted;

    // With both requesting, the one that did not win last is served
    assign gnt_any    = req0_valid | req1_valid;
    assign gnt_id     = (req0_valid & req1_valid) ? ~last_gnt : req1_valid;
    assign can_accept = (state == EMPTY) | out_ready;
    assign accept     = can_accept & gnt_any;
    assign req0_ready = accept & (gnt_id == REQ0);
    assign req1_ready = accept & (gnt_id == REQ1);

    assign sel_data = (gnt_id == REQ1) ? req1_data : req0_data;
    assign sel_amt  = (gnt_id == REQ1) ? req1_amt  : req0_amt;

    lshift8_stage u_shift (
        .data   (sel_data),
        .amt    (sel_amt),
`ifdef SHIFT_ARB_ROTATE_EN
        .rot    ((gnt_id == REQ1) ? req1_rot : req0_rot),
`endif
        .result (shifted)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= REQ0;
            last_gnt  <= REQ1;
            done_cnt  <= '0;
        end else begin
            if (out_valid && out_ready && (done_cnt != '1)) begin
                done_cnt <= done_cnt + CNT_W'(1);
            end
            if (accept) begin
                out_data <= shifted;
                out_id   <= gnt_id;
                last_gnt <= gnt_id;
            end
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state     <= FULL;
                        out_valid <= 1'b1;
                    end
                end
                FULL: begin
                    // Drain without refill empties the slot; data/id keep their last value
                    if (out_ready && !accept) begin
                        state     <= EMPTY;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_arbiter.sv
// tb/tb_shift_arbiter.sv - self-checking bench for shift_arbiter (directed scenarios plus randomized model run)
module tb_shift_arbiter;

    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req0_valid = 1'b0;
    logic [7:0]       req0_data = '0;
    logic [2:0]       req0_amt = '0;
    logic             req0_ready;
    logic             req1_valid = 1'b0;
    logic [7:0]       req1_data = '0;
    logic [2:0]       req1_amt = '0;
    logic             req1_ready;
    logic             out_valid;
    logic [7:0]       out_data;
    logic             out_id;
    logic             out_ready = 1'b0;
    logic [CNT_W-1:0] done_cnt;

    int total = 0;
    int bad   = 0;

    shift_arbiter #(.DATA_W(8), .SH_W(3), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_amt   (req0_amt),
`ifdef SHIFT_ARB_ROTATE_EN
        .req0_rot   (1'b0),
`endif
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_amt   (req1_amt),
`ifdef SHIFT_ARB_ROTATE_EN
        .req1_rot   (1'b0),
`endif
        .req1_ready (req1_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_id     (out_id),
        .out_ready  (out_ready),
        .done_cnt   (done_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req0_data = '0; req0_amt = '0;
        req1_valid = 1'b0; req1_data = '0; req1_amt = '0;
        out_ready  = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
        total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_out_data got=%02h want=00", out_data); end
        total++; if (out_id !== 1'b0) begin bad++; $display("FAIL reset_out_id got=%0b want=0", out_id); end
        total++; if (done_cnt !== '0) begin bad++; $display("FAIL reset_done_cnt got=%0d want=0", done_cnt); end
        total++; if ({req0_ready, req1_ready} !== 2'b00) begin bad++; $display("FAIL reset_ready got=%02b want=00", {req0_ready, req1_ready}); end
    endtask

    task automatic test_first_op();
        req0_valid = 1'b1; req0_data = 8'h81; req0_amt = 3'd1; out_ready = 1'b1;
        #1;
        total++; if ({req0_ready, req1_ready} !== 2'b10) begin bad++; $display("FAIL first_ready got=%02b want=10", {req0_ready, req1_ready}); end
        tick();
        req0_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || out_data !== 8'h02 || out_id !== 1'b0)
            begin bad++; $display("FAIL first_result got=v%0b d%02h id%0b want=v1 d02 id0", out_valid, out_data, out_id); end
        total++; if (done_cnt !== 8'd0) begin bad++; $display("FAIL first_cnt_early got=%0d want=0", done_cnt); end
        tick();
        total++; if (done_cnt !== 8'd1) begin bad++; $display("FAIL first_cnt got=%0d want=1", done_cnt); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL first_drain got=%0b want=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic       g;
        logic [7:0] exp_d;
        do_reset();
        req0_valid = 1'b1; req0_data = 8'h01; req0_amt = 3'd3;
        req1_valid = 1'b1; req1_data = 8'h0F; req1_amt = 3'd4;
        out_ready  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            g     = i[0];
            exp_d = g ? 8'hF0 : 8'h08;
            #1;
            total++; if ({req1_ready, req0_ready} !== {g, ~g})
                begin bad++; $display("FAIL b2b_ready[%0d] got=%02b want=%0b%0b", i, {req1_ready, req0_ready}, g, ~g); end
            tick();
            total++; if (out_valid !== 1'b1 || out_data !== exp_d || out_id !== g)
                begin bad++; $display("FAIL b2b_result[%0d] got=v%0b d%02h id%0b want=v1 d%02h id%0b", i, out_valid, out_data, out_id, exp_d, g); end
        end
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++; if ({req0_ready, req1_ready} !== 2'b00)
                begin bad++; $display("FAIL stall_ready[%0d] got=%02b want=00", i, {req0_ready, req1_ready}); end
            tick();
            total++; if (out_valid !== 1'b1 || out_data !== 8'hF0 || out_id !== 1'b1)
                begin bad++; $display("FAIL stall_hold[%0d] got=v%0b d%02h id%0b want=v1 dF0 id1", i, out_valid, out_data, out_id); end
        end
        out_ready = 1'b1;
        #1;
        total++; if ({req0_ready, req1_ready} !== 2'b10)
            begin bad++; $display("FAIL stall_release_ready got=%02b want=10", {req0_ready, req1_ready}); end
        tick();
        total++; if (out_data !== 8'h08 || out_id !== 1'b0)
            begin bad++; $display("FAIL stall_release_result got=d%02h id%0b want=d08 id0", out_data, out_id); end
        idle_inputs();
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_amt_sweep();
        logic [7:0] ones;
        logic [7:0] exp_d;
        ones = 8'hFF;
        out_ready = 1'b1;
        req1_valid = 1'b1; req1_data = 8'hFF;
        for (int a = 0; a < 8; a++) begin
            req1_amt = 3'(a);
            exp_d    = 8'(ones << a);
            #1;
            total++; if (req1_ready !== 1'b1) begin bad++; $display("FAIL sweep_ready[%0d] got=%0b want=1", a, req1_ready); end
            tick();
            total++; if (out_data !== exp_d || out_id !== 1'b1)
                begin bad++; $display("FAIL sweep_result[%0d] got=%02h id%0b want=%02h id1", a, out_data, out_id, exp_d); end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_random();
        logic       m_valid, m_id, m_last, free, e0, e1, acc0, acc1;
        logic [7:0] m_data;
        int         m_cnt;
        do_reset();
        m_valid = 1'b0; m_data = '0; m_id = 1'b0; m_last = 1'b1; m_cnt = 0;
        acc0 = 1'b1; acc1 = 1'b1;
        for (int c = 0; c < 400; c++) begin
            // A requester may only change its operation after it was accepted
            if (!req0_valid || acc0) begin
                req0_valid = ($urandom_range(0, 1) == 1);
                req0_data  = 8'($urandom); req0_amt = 3'($urandom);
            end
            if (!req1_valid || acc1) begin
                req1_valid = ($urandom_range(0, 1) == 1);
                req1_data  = 8'($urandom); req1_amt = 3'($urandom);
            end
            out_ready = ($urandom_range(0, 9) < 7);
            free = !m_valid || out_ready;
            if (req0_valid && req1_valid) begin
                e0 = free && (m_last == 1'b1);
                e1 = free && (m_last == 1'b0);
            end else begin
                e0 = free && req0_valid;
                e1 = free && req1_valid;
            end
            #1;
            total++; if ({req0_ready, req1_ready} !== {e0, e1})
                begin bad++; $display("FAIL rand_ready[%0d] got=%02b want=%0b%0b", c, {req0_ready, req1_ready}, e0, e1); end
            if (m_valid && out_ready && m_cnt < CNT_MAX) m_cnt++;
            if (e0) begin
                m_valid = 1'b1; m_data = 8'(req0_data << req0_amt); m_id = 1'b0; m_last = 1'b0;
            end else if (e1) begin
                m_valid = 1'b1; m_data = 8'(req1_data << req1_amt); m_id = 1'b1; m_last = 1'b1;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
            acc0 = e0; acc1 = e1;
            tick();
            total++; if (out_valid !== m_valid || out_data !== m_data || out_id !== m_id || done_cnt !== CNT_W'(m_cnt))
                begin bad++; $display("FAIL rand_out[%0d] got=v%0b d%02h id%0b n%0d want=v%0b d%02h id%0b n%0d",
                    c, out_valid, out_data, out_id, done_cnt, m_valid, m_data, m_id, m_cnt); end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid();
        req0_valid = 1'b1; req0_data = 8'h01; req0_amt = 3'd3;
        out_ready  = 1'b1;
        tick();
        req0_valid = 1'b0; out_ready = 1'b0;
        tick();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL mid_setup got=%0b want=1", out_valid); end
        rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0 || done_cnt !== '0)
            begin bad++; $display("FAIL mid_async got=v%0b n%0d want=v0 n0", out_valid, done_cnt); end
        req0_valid = 1'b1; req0_data = 8'h01; req0_amt = 3'd3;
        req1_valid = 1'b1; req1_data = 8'h0F; req1_amt = 3'd4;
        out_ready  = 1'b1;
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_held got=%0b want=0", out_valid); end
        rst_n = 1'b1;
        #1;
        total++; if ({req0_ready, req1_ready} !== 2'b10)
            begin bad++; $display("FAIL mid_first_grant got=%02b want=10", {req0_ready, req1_ready}); end
        tick();
        total++; if (out_valid !== 1'b1 || out_data !== 8'h08 || out_id !== 1'b0)
            begin bad++; $display("FAIL mid_first_result got=v%0b d%02h id%0b want=v1 d08 id0", out_valid, out_data, out_id); end
        idle_inputs();
        tick();
    endtask

    task automatic test_saturate();
        do_reset();
        req0_valid = 1'b1; req0_data = 8'h11; req0_amt = 3'd0;
        out_ready  = 1'b1;
        for (int k = 1; k <= CNT_MAX + 45; k++) begin
            tick();
            if (k == CNT_MAX) begin
                total++; if (done_cnt !== CNT_W'(CNT_MAX - 1))
                    begin bad++; $display("FAIL sat_before got=%0d want=%0d", done_cnt, CNT_MAX - 1); end
            end
            if (k == CNT_MAX + 1 || k == CNT_MAX + 45) begin
                total++; if (done_cnt !== CNT_W'(CNT_MAX))
                    begin bad++; $display("FAIL sat_hold[%0d] got=%0d want=%0d", k, done_cnt, CNT_MAX); end
            end
        end
        total++; if (out_data !== 8'h11) begin bad++; $display("FAIL sat_data got=%02h want=11", out_data); end
        idle_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_first_op();
        test_back_to_back();
        test_stall();
        test_amt_sweep();
        test_random();
        test_reset_mid();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
